calc_accum_unit: RTL and testbench
==================================

CALC_ACCUM_UNIT -- requirements
Module: calc_accum_unit

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, datapath and accumulator width; legal range is WIDTH >= IMM_W.
REQ-002 The block SHALL provide parameter IMM_W, default 14, immediate operand width; legal range is IMM_W >= 2.
REQ-003 The block SHALL provide parameter NACC, default 4, number of accumulators; legal values are powers of 2 >= 2; AW = log2(NACC).
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-005 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 instr_valid  input  1  instruction present.
REQ-007 instr_ready  output  1  block can accept an instruction.
REQ-008 opcode  input  3  operation select.
REQ-009 acc_sel  input  AW  destination/source accumulator.
REQ-010 imm_a, imm_b  input  IMM_W each  two's-complement immediates, sign-extended to WIDTH.
REQ-011 result_valid  output  1  one-cycle pulse marking result, result_acc and flags as valid.
REQ-012 result  output  WIDTH  operation result.
REQ-013 result_acc  output  AW  accumulator written.
REQ-014 overflow, zero  output  1 each  signed-overflow flag and result==0 flag.

Function
REQ-015 Accept SHALL occur on a rising edge where instr_valid && instr_ready; when instr_valid is low, or instr_ready is low, the instruction SHALL be ignored with no state change.
REQ-016 The FSM SHALL have states IDLE and MUL; instr_ready SHALL be 1 in IDLE and 0 in MUL.
REQ-017 Opcodes, with A = sext(imm_a), B = sext(imm_b), R = acc[acc_sel]:
- 000 NOP: no write, no result_valid.
- 001 ADD: A+B.
- 010 SUB: A-B.
- 011 ACCADD: A+R.
- 100 ACCSUB: A-R.
- 101 CLR: 0.
- 110 READ: R, with no accumulator write.
- 111 MUL: low WIDTH bits of A*B.
REQ-018 Single-cycle ops (001-110): on the accept edge, acc[acc_sel] SHALL take the op value (except READ), and result/result_acc/flags SHALL be registered.
REQ-019 For single-cycle ops, result_valid SHALL be 1 in the cycle after accept (latency 1), and the FSM SHALL stay in IDLE, giving one instruction per cycle.
REQ-020 Back-to-back instructions SHALL see the accumulator value written by the previous instruction, with no bubbles.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH.
REQ-022 overflow SHALL be the signed overflow of the add/sub for ops 001-100, and 0 for CLR, READ and MUL.
REQ-023 zero SHALL be (result == 0) for every op that produces a result.
REQ-024 MUL SHALL load the operands on the accept edge and move to MUL; it SHALL then run a shift-add over the WIDTH bits of B, one bit per cycle, counting 0..WIDTH-1.
REQ-025 On the edge ending iteration WIDTH-1, MUL SHALL write acc[acc_sel], register result/flags, and return to IDLE.
REQ-026 MUL result_valid SHALL be asserted exactly WIDTH cycles after accept, and instr_ready SHALL rise in the same cycle.
REQ-027 MUL signed results SHALL be correct modulo 2^WIDTH, using the two's-complement property of the low product bits.
REQ-028 Accumulators not addressed by acc_sel SHALL never change.
REQ-029 result, result_acc, overflow and zero SHALL hold their last values while result_valid is 0.
REQ-030 result_valid SHALL be 0 in every cycle that does not complete an operation.

Reset
REQ-031 While reset_n = 0 at a clock edge, the block SHALL:
- set all accumulators, result, result_acc, overflow, zero and result_valid to 0;
- force the FSM to IDLE and clear the iteration counter.
REQ-032 instr_ready SHALL be 0 while reset_n is low, and 1 in the first cycle after reset_n is sampled high.
REQ-033 A reset during MUL SHALL abort the operation; no result_valid SHALL be produced for it, and no accumulator write SHALL occur.
REQ-034 An instr_valid presented in the same cycle that reset_n is sampled low SHALL be discarded.

Verification
REQ-035 ADD, imm_a=0x1FFF, imm_b=0x2000, acc_sel=1 (WIDTH=32) -> next cycle: result_valid=1, result=0xFFFFFFFF, result_acc=1, overflow=0, zero=0.
REQ-036 CLR acc2, then 3 back-to-back ACCADD imm_a=5, acc_sel=2 -> results 0, 5, 10, 15 on consecutive cycles; READ acc2 then returns 15.
REQ-037 WIDTH=IMM_W=14: ADD imm_a=0x1FFF, imm_b=0x0001 -> result=0x2000, overflow=1; SUB 0x0000-0x0000 -> result=0, zero=1.
REQ-038 MUL imm_a=0x3FFD (-3), imm_b=7, acc_sel=3 (WIDTH=32):
- instr_ready=0 for 32 cycles, and instr_valid pulses during that window are ignored;
- result=0xFFFFFFEB with result_valid exactly 32 cycles after accept;
- acc3=0xFFFFFFEB.
REQ-039 Start MUL, drive reset_n=0 at cycle 10 for one edge, then release -> no result_valid occurs, READ of each accumulator returns 0, and instr_ready=1 in the first cycle after release.
REQ-040 Random op stream checked against a reference model, covering each of the 8 opcodes and each acc_sel, with instr_valid toggling randomly -> every field matches.

Source files
------------

// File: rtl/calc_accum_unit.sv
// rtl/calc_accum_unit.sv - accumulator calculator with single-cycle ALU ops and a serial shift-add multiplier
module calc_accum_unit #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 14,
    parameter int NACC  = 4,
    localparam int AW   = $clog2(NACC)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       opcode,
    input  logic [AW-1:0]    acc_sel,
    input  logic [IMM_W-1:0] imm_a,
    input  logic [IMM_W-1:0] imm_b,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [AW-1:0]    result_acc,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int M  = WIDTH - 1;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_ACCADD = 3'b011;
    localparam logic [2:0] OP_ACCSUB = 3'b100;
    localparam logic [2:0] OP_CLR    = 3'b101;
    localparam logic [2:0] OP_READ   = 3'b110;
    localparam logic [2:0] OP_MUL    = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_acc [NACC];
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_prod;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_mul_sel;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_op_val;
    logic             w_op_ovf;
    logic             w_op_wr;
    logic             w_accept;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_prod_nxt;

    assign w_a = WIDTH'($signed(imm_a));
    assign w_b = WIDTH'($signed(imm_b));
    assign w_r = r_acc[acc_sel];

    assign instr_ready = reset_n && (r_state == S_IDLE);
    assign w_accept    = instr_valid && instr_ready;

    // Low WIDTH bits of the unsigned product of the sign-extended operands equal the signed product.
    assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_op_val = '0;
        w_op_ovf = 1'b0;
        w_op_wr  = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_op_val = w_a + w_b;
                w_op_ovf = (w_a[M] == w_b[M]) && (w_op_val[M] != w_a[M]);
                w_op_wr  = 1'b1;
            end
            OP_SUB: begin
                w_op_val = w_a - w_b;
                w_op_ovf = (w_a[M] != w_b[M]) && (w_op_val[M] != w_a[M]);
                w_op_wr  = 1'b1;
            end
            OP_ACCADD: begin
                w_op_val = w_a + w_r;
                w_op_ovf = (w_a[M] == w_r[M]) && (w_op_val[M] != w_a[M]);
                w_op_wr  = 1'b1;
            end
            OP_ACCSUB: begin
                w_op_val = w_a - w_r;
                w_op_ovf = (w_a[M] != w_r[M]) && (w_op_val[M] != w_a[M]);
                w_op_wr  = 1'b1;
            end
            OP_CLR: begin
                w_op_val = '0;
                w_op_wr  = 1'b1;
            end
            OP_READ: begin
                w_op_val = w_r;
            end
            default: begin
                w_op_val = '0;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && (opcode == OP_MUL)) w_state_nxt = S_MUL;
            S_MUL:  if (w_mul_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NACC; i++) begin
                r_acc[i] <= '0;
            end
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_prod       <= '0;
            r_cnt        <= '0;
            r_mul_sel    <= '0;
            result_valid <= 1'b0;
            result       <= '0;
            result_acc   <= '0;
            overflow     <= 1'b0;
            zero         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (r_state == S_MUL) begin
                r_prod   <= w_prod_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_mul_last) begin
                    r_acc[r_mul_sel] <= w_prod_nxt;
                    result           <= w_prod_nxt;
                    result_acc       <= r_mul_sel;
                    overflow         <= 1'b0;
                    zero             <= (w_prod_nxt == '0);
                    result_valid     <= 1'b1;
                    r_cnt            <= '0;
                end
            end else if (w_accept) begin
                if (opcode == OP_MUL) begin
                    r_mcand   <= w_a;
                    r_mplier  <= w_b;
                    r_prod    <= '0;
                    r_cnt     <= '0;
                    r_mul_sel <= acc_sel;
                end else if (opcode != OP_NOP) begin
                    if (w_op_wr) begin
                        r_acc[acc_sel] <= w_op_val;
                    end
                    result       <= w_op_val;
                    result_acc   <= acc_sel;
                    overflow     <= w_op_ovf;
                    zero         <= (w_op_val == '0);
                    result_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_accum_unit.sv
// tb/tb_calc_accum_unit.sv - self-checking bench for calc_accum_unit
module tb_calc_accum_unit;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  opcode;
    logic [1:0]  acc_sel;
    logic [13:0] imm_a, imm_b;
    logic        result_valid;
    logic [31:0] result;
    logic [1:0]  result_acc;
    logic        overflow, zero;

    logic        v14, rdy14, rv14, ovf14, z14;
    logic [2:0]  op14;
    logic [1:0]  sel14, racc14;
    logic [13:0] a14, b14, res14;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc_accum_unit #(.WIDTH(32), .IMM_W(14), .NACC(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .acc_sel(acc_sel), .imm_a(imm_a), .imm_b(imm_b),
        .result_valid(result_valid), .result(result), .result_acc(result_acc),
        .overflow(overflow), .zero(zero)
    );

    calc_accum_unit #(.WIDTH(14), .IMM_W(14), .NACC(4)) u_dut14 (
        .clk(clk), .reset_n(reset_n), .instr_valid(v14), .instr_ready(rdy14),
        .opcode(op14), .acc_sel(sel14), .imm_a(a14), .imm_b(b14),
        .result_valid(rv14), .result(res14), .result_acc(racc14),
        .overflow(ovf14), .zero(z14)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  sel;
        logic [13:0] a;
        logic [13:0] b;
        logic        ev;
        logic [31:0] res;
        logic [1:0]  racc;
        logic        ovf;
        logic        zro;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] sel,
                         input logic [13:0] a, input logic [13:0] b);
        instr_valid = v;
        opcode      = op;
        acc_sel     = sel;
        imm_a       = a;
        imm_b       = b;
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [31:0] res,
                           input logic [1:0] racc, input logic ovf, input logic zro);
        chk({nm, ".valid"}, 64'(result_valid), 64'(ev));
        chk({nm, ".result"}, 64'(result), 64'(res));
        chk({nm, ".acc"}, 64'(result_acc), 64'(racc));
        chk({nm, ".ovf"}, 64'(overflow), 64'(ovf));
        chk({nm, ".zero"}, 64'(zero), 64'(zro));
    endtask

    // Reference model: plain signed integer arithmetic on a 4-entry accumulator array
    logic [31:0] m_acc [4];
    int          busy;
    logic [31:0] p_res;
    logic [1:0]  p_sel;
    logic        e_v, e_ovf, e_zero;
    logic [31:0] e_res;
    logic [1:0]  e_acc;

    task automatic model_exec(input logic [2:0] op, input logic [1:0] sel,
                              input logic [13:0] a, input logic [13:0] b);
        longint la, lb, lr, s;
        la = $signed(a);
        lb = $signed(b);
        lr = $signed(m_acc[sel]);
        s  = 0;
        case (op)
            3'd1: s = la + lb;
            3'd2: s = la - lb;
            3'd3: s = la + lr;
            3'd4: s = la - lr;
            3'd5: s = 0;
            3'd6: s = lr;
            default: s = 0;
        endcase
        if (op == 3'd7) begin
            s     = la * lb;
            p_res = s[31:0];
            p_sel = sel;
            busy  = W;
        end else if (op != 3'd0) begin
            e_v    = 1'b1;
            e_res  = s[31:0];
            e_acc  = sel;
            e_ovf  = (op <= 3'd4) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            e_zero = (s[31:0] == 32'd0);
            if (op != 3'd6) m_acc[sel] = s[31:0];
        end
    endtask

    initial begin
        int pulses;
        logic        rv;
        logic [2:0]  rop;
        logic [1:0]  rsel;
        logic [13:0] ra, rb;
        logic        m_ready, acc_ok;

        tbl[0]  = '{3'd1, 2'd1, 14'h1FFF, 14'h2000, 1'b1, 32'hFFFFFFFF, 2'd1, 1'b0, 1'b0};
        tbl[1]  = '{3'd5, 2'd2, 14'h0000, 14'h0000, 1'b1, 32'h00000000, 2'd2, 1'b0, 1'b1};
        tbl[2]  = '{3'd3, 2'd2, 14'h0005, 14'h0000, 1'b1, 32'h00000005, 2'd2, 1'b0, 1'b0};
        tbl[3]  = '{3'd3, 2'd2, 14'h0005, 14'h0000, 1'b1, 32'h0000000A, 2'd2, 1'b0, 1'b0};
        tbl[4]  = '{3'd3, 2'd2, 14'h0005, 14'h0000, 1'b1, 32'h0000000F, 2'd2, 1'b0, 1'b0};
        tbl[5]  = '{3'd6, 2'd2, 14'h0000, 14'h0000, 1'b1, 32'h0000000F, 2'd2, 1'b0, 1'b0};
        tbl[6]  = '{3'd4, 2'd1, 14'h0000, 14'h0000, 1'b1, 32'h00000001, 2'd1, 1'b0, 1'b0};
        tbl[7]  = '{3'd2, 2'd0, 14'h2000, 14'h1FFF, 1'b1, 32'hFFFFC001, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{3'd6, 2'd0, 14'h0000, 14'h0000, 1'b1, 32'hFFFFC001, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{3'd0, 2'd3, 14'h0123, 14'h0456, 1'b0, 32'hFFFFC001, 2'd0, 1'b0, 1'b0};
        tbl[10] = '{3'd1, 2'd3, 14'h0000, 14'h0000, 1'b1, 32'h00000000, 2'd3, 1'b0, 1'b1};
        tbl[11] = '{3'd6, 2'd1, 14'h0000, 14'h0000, 1'b1, 32'h00000001, 2'd1, 1'b0, 1'b0};
        tbl[12] = '{3'd3, 2'd3, 14'h3FFF, 14'h0000, 1'b1, 32'hFFFFFFFF, 2'd3, 1'b0, 1'b0};

        reset_n = 1'b0;
        drive(1'b0, 3'd0, 2'd0, 14'd0, 14'd0);
        v14 = 1'b0; op14 = 3'd0; sel14 = 2'd0; a14 = '0; b14 = '0;
        tick();
        tick();
        chk_out("reset", 1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
        chk("reset.ready", 64'(instr_ready), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("release.ready", 64'(instr_ready), 64'd1);

        // 14-bit datapath boundary: overflow into the sign bit and zero flag
        v14 = 1'b1; op14 = 3'd1; a14 = 14'h1FFF; b14 = 14'h0001;
        tick();
        chk("w14_add.valid", 64'(rv14), 64'd1);
        chk("w14_add.result", 64'(res14), 64'h2000);
        chk("w14_add.ovf", 64'(ovf14), 64'd1);
        chk("w14_add.zero", 64'(z14), 64'd0);
        op14 = 3'd2; a14 = 14'h0000; b14 = 14'h0000;
        tick();
        chk("w14_sub.result", 64'(res14), 64'h0);
        chk("w14_sub.ovf", 64'(ovf14), 64'd0);
        chk("w14_sub.zero", 64'(z14), 64'd1);
        v14 = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].sel, tbl[i].a, tbl[i].b);
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].res, tbl[i].racc, tbl[i].ovf, tbl[i].zro);
        end
        drive(1'b0, 3'd0, 2'd0, 14'd0, 14'd0);

        // MUL -3 * 7 into acc3 with ignored instruction pulses during the busy window
        drive(1'b1, 3'd7, 2'd3, 14'h3FFD, 14'h0007);
        tick();
        for (int k = 0; k < W; k++) begin
            chk($sformatf("mul_busy%0d.ready", k), 64'(instr_ready), 64'd0);
            chk($sformatf("mul_busy%0d.valid", k), 64'(result_valid), 64'd0);
            drive(1'(k % 2), 3'd1, 2'd0, 14'd1, 14'd1);
            tick();
        end
        drive(1'b0, 3'd0, 2'd0, 14'd0, 14'd0);
        chk_out("mul_done", 1'b1, 32'hFFFFFFEB, 2'd3, 1'b0, 1'b0);
        chk("mul_done.ready", 64'(instr_ready), 64'd1);
        drive(1'b1, 3'd6, 2'd3, 14'd0, 14'd0);
        tick();
        chk_out("read_acc3", 1'b1, 32'hFFFFFFEB, 2'd3, 1'b0, 1'b0);
        drive(1'b1, 3'd6, 2'd0, 14'd0, 14'd0);
        tick();
        chk_out("read_acc0", 1'b1, 32'hFFFFC001, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of a MUL aborts it
        drive(1'b1, 3'd7, 2'd1, 14'd5, 14'd5);
        tick();
        drive(1'b0, 3'd0, 2'd0, 14'd0, 14'd0);
        repeat (9) tick();
        reset_n = 1'b0;
        drive(1'b1, 3'd1, 2'd2, 14'd1, 14'd1);
        #1;
        chk("abort.ready_low", 64'(instr_ready), 64'd0);
        tick();
        chk("abort.valid", 64'(result_valid), 64'd0);
        chk("abort.result", 64'(result), 64'd0);
        reset_n = 1'b1;
        drive(1'b0, 3'd0, 2'd0, 14'd0, 14'd0);
        tick();
        chk("abort.ready_release", 64'(instr_ready), 64'd1);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (result_valid) pulses++;
            tick();
        end
        chk("abort.no_valid", 64'(pulses), 64'd0);
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 3'd6, 2'(s), 14'd0, 14'd0);
            tick();
            chk_out($sformatf("abort_read%0d", s), 1'b1, 32'd0, 2'(s), 1'b0, 1'b1);
        end
        drive(1'b0, 3'd0, 2'd0, 14'd0, 14'd0);
        tick();

        // Randomized stream against the reference model
        for (int s = 0; s < 4; s++) m_acc[s] = 32'd0;
        busy = 0;
        e_v = 1'b0; e_res = 32'd0; e_acc = 2'd3; e_ovf = 1'b0; e_zero = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rv   = ($urandom % 4) != 0;
            rop  = 3'($urandom);
            rsel = 2'($urandom);
            ra   = 14'($urandom);
            rb   = 14'($urandom);
            if ((cyc % 5) == 0) ra = 14'($urandom_range(0, 3)) - 14'd1;
            drive(rv, rop, rsel, ra, rb);
            m_ready = (busy == 0);
            acc_ok  = rv && m_ready;
            chk("rnd.ready", 64'(instr_ready), 64'(m_ready));
            tick();
            e_v = 1'b0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    e_v = 1'b1; e_res = p_res; e_acc = p_sel; e_ovf = 1'b0;
                    e_zero = (p_res == 32'd0);
                    m_acc[p_sel] = p_res;
                end
            end else if (acc_ok) begin
                model_exec(rop, rsel, ra, rb);
            end
            chk_out("rnd", e_v, e_res, e_acc, e_ovf, e_zero);
        end
        drive(1'b0, 3'd0, 2'd0, 14'd0, 14'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
